multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multicycle successor to the single-cycle opcode decoder: a Moore/Mealy FSM that sequences each MIPS instruction over 3–5 cycles through shared memory and ALU.
- Decodes the same opcode set: R-type, ADDI, ORI, ANDI, LUI, LW, SW, BEQ, BNE, J, JAL.
- Adds a memory ready handshake, a latched opcode, illegal-opcode flagging and a retired-instruction counter.
- Sits between the instruction register and the multicycle datapath muxes and enables.

Parameters:
- ALUOP_WIDTH, 3: width of alu_op. Codes are zero-extended when wider: AND 0, OR 1, NOR 2, ADD 3, SUB 4, LUI 5, FUNCT 7.
- COUNT_WIDTH, 32: width of instr_count.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- op  input  6  instruction[31:26] from the IR; valid from DECODE onward
- mem_ready  input  1  memory has completed the current read or write this cycle
- pc_write  output  1  unconditional PC load
- pc_write_beq  output  1  PC load if ALU zero
- pc_write_bne  output  1  PC load if ALU not zero
- iord  output  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  IR load
- reg_dst  output  1  1 = rd, 0 = rt
- mem_to_reg  output  1  write-back from MDR
- reg_write  output  1  register file write enable
- link  output  1  write PC+4 to $31 (JAL)
- alu_src_a  output  1  0 = PC, 1 = A register
- alu_src_b  output  2  0 = B, 1 = constant 4, 2 = imm, 3 = imm<<2
- pc_source  output  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- zero_imm  output  1  zero-extend the immediate instead of sign-extending
- alu_op  output  ALUOP_WIDTH  ALU operation code
- state  output  4  current state encoding, for debug
- illegal_op  output  1  one-cycle pulse on an undefined opcode
- instr_count  output  COUNT_WIDTH  retired instruction count

Behaviour:
- Reset (asynchronous):
  - state = FETCH, op_q = 0, instr_count = 0, illegal_op = 0.
  - All outputs take their FETCH values with mem_ready treated as low.
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11, JAL 12. Any other encoding returns to FETCH on the next edge.
- Default for every output not listed in a state is 0.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_source=0.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1 (Mealy).
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target precomputation).
  - op_q <= op.
  - Next state by op:
    - 0x00 -> R_EXEC
    - 0x23, 0x2b -> MEM_ADDR
    - 0x04, 0x05 -> BRANCH
    - 0x02 -> JUMP
    - 0x03 -> JAL
    - 0x08, 0x0d, 0x0c, 0x0f -> I_EXEC
    - anything else -> FETCH, with illegal_op=1 for exactly one cycle on the next edge; instr_count unchanged.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=ADD. Goes to MEM_RD if op_q=0x23, else MEM_WR.
- MEM_RD: mem_read=1, iord=1. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
- MEM_WR: mem_write=1, iord=1. Waits for mem_ready, then goes to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=0, alu_op=FUNCT. Goes to R_WB.
- R_WB: reg_write=1, reg_dst=1. Goes to FETCH.
- I_EXEC:
  - Common: alu_src_a=1, alu_src_b=2.
  - alu_op from op_q: ADDI ADD, ORI OR, ANDI AND, LUI LUI.
  - zero_imm=1 for ORI and ANDI only.
  - Goes to I_WB.
- I_WB: reg_write=1, reg_dst=0, with zero_imm and alu_op held from I_EXEC. Goes to FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_source=1.
  - pc_write_beq=1 if op_q=0x04; pc_write_bne=1 if op_q=0x05.
  - Goes to FETCH.
- JUMP: pc_write=1, pc_source=2. Goes to FETCH.
- JAL: pc_write=1, pc_source=2, reg_write=1, link=1. Goes to FETCH.
- Instruction retirement:
  - instr_count increments by 1 on every edge that enters FETCH from a non-FETCH state, except the illegal-op path from DECODE.
  - Wraps modulo 2^COUNT_WIDTH.
- Latency (mem_ready=1 in FETCH): LW 5 cycles; SW, R-type and I-type 4 cycles; BEQ, BNE, J and JAL 3 cycles.
- Wait states: each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle. The request outputs stay asserted and stable throughout.
- mem_ready high outside FETCH, MEM_RD and MEM_WR is ignored.
- op changes after DECODE have no effect.
- Reset mid-instruction: immediate return to FETCH and counter clear. No write enable may glitch high during or after reset.

Test Plan:
- Reset asserted mid-MEM_WR (state 5) -> state=0 and mem_write=0 asynchronously; instr_count=0; after release, first FETCH drives mem_read=1, alu_src_b=1.
- LW (op=0x23) with mem_ready held high -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; instr_count 0->1.
- ORI (op=0x0d) -> sequence 0,1,10,11,0; alu_op=1 and zero_imm=1 in states 10 and 11; ADDI (0x08) gives alu_op=3, zero_imm=0.
- BNE (op=0x05) -> sequence 0,1,8,0; pc_write_bne=1 and pc_write_beq=0 in state 8; alu_op=4.
- FETCH with mem_ready low for 3 cycles, then high -> state held at 0 with mem_read=1; ir_write and pc_write are 0 for 3 cycles, then 1 for exactly 1 cycle.
- op=0x3f at DECODE -> next state 0; illegal_op high for 1 cycle; instr_count unchanged. Separately, run 2^COUNT_WIDTH J instructions with COUNT_WIDTH=4 -> count wraps 15->0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences each instruction over 3-5 cycles,
// with memory handshake, latched opcode, illegal-op flag and retire counter.
module multicycle_control #(
    parameter int ALUOP_WIDTH = 3,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             op,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   pc_write_beq,
    output logic                   pc_write_bne,
    output logic                   iord,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic                   reg_dst,
    output logic                   mem_to_reg,
    output logic                   reg_write,
    output logic                   link,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [1:0]             pc_source,
    output logic                   zero_imm,
    output logic [ALUOP_WIDTH-1:0] alu_op,
    output logic [3:0]             state,
    output logic                   illegal_op,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11,
        S_JAL      = 4'd12
    } state_t;

    localparam logic [ALUOP_WIDTH-1:0] ALU_AND   = ALUOP_WIDTH'(0);
    localparam logic [ALUOP_WIDTH-1:0] ALU_OR    = ALUOP_WIDTH'(1);
    localparam logic [ALUOP_WIDTH-1:0] ALU_ADD   = ALUOP_WIDTH'(3);
    localparam logic [ALUOP_WIDTH-1:0] ALU_SUB   = ALUOP_WIDTH'(4);
    localparam logic [ALUOP_WIDTH-1:0] ALU_LUI   = ALUOP_WIDTH'(5);
    localparam logic [ALUOP_WIDTH-1:0] ALU_FUNCT = ALUOP_WIDTH'(7);

    state_t     cur;
    state_t     nxt;
    logic [5:0] op_q;
    logic       illegal_d;
    logic       retire;

    function automatic logic [ALUOP_WIDTH-1:0] imm_alu(input logic [5:0] o);
        case (o)
            6'h0d:   return ALU_OR;
            6'h0c:   return ALU_AND;
            6'h0f:   return ALU_LUI;
            default: return ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur         <= S_FETCH;
            op_q        <= 6'd0;
            illegal_op  <= 1'b0;
            instr_count <= '0;
        end else begin
            cur        <= nxt;
            illegal_op <= illegal_d;
            if (cur == S_DECODE)
                op_q <= op;
            if (retire)
                instr_count <= instr_count + COUNT_WIDTH'(1);
        end
    end

    always_comb begin
        nxt          = S_FETCH;
        illegal_d    = 1'b0;
        pc_write     = 1'b0;
        pc_write_beq = 1'b0;
        pc_write_bne = 1'b0;
        iord         = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        reg_write    = 1'b0;
        link         = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'd0;
        pc_source    = 2'd0;
        zero_imm     = 1'b0;
        alu_op       = ALU_AND;
        case (cur)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                alu_op    = ALU_ADD;
                // Gated by reset so the Mealy enables cannot pulse during reset
                if (mem_ready && !reset) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    nxt      = S_DECODE;
                end else begin
                    nxt = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                alu_op    = ALU_ADD;
                case (op)
                    6'h00:                      nxt = S_R_EXEC;
                    6'h23, 6'h2b:               nxt = S_MEM_ADDR;
                    6'h04, 6'h05:               nxt = S_BRANCH;
                    6'h02:                      nxt = S_JUMP;
                    6'h03:                      nxt = S_JAL;
                    6'h08, 6'h0d, 6'h0c, 6'h0f: nxt = S_I_EXEC;
                    default: begin
                        nxt       = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = ALU_ADD;
                nxt       = (op_q == 6'h23) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                nxt      = mem_ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                nxt       = mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                nxt       = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = imm_alu(op_q);
                zero_imm  = (op_q == 6'h0d) || (op_q == 6'h0c);
                nxt       = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                alu_op    = imm_alu(op_q);
                zero_imm  = (op_q == 6'h0d) || (op_q == 6'h0c);
            end
            S_BRANCH: begin
                alu_src_a    = 1'b1;
                alu_op       = ALU_SUB;
                pc_source    = 2'd1;
                pc_write_beq = (op_q == 6'h04);
                pc_write_bne = (op_q == 6'h05);
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'd2;
            end
            S_JAL: begin
                pc_write  = 1'b1;
                pc_source = 2'd2;
                reg_write = 1'b1;
                link      = 1'b1;
            end
            default: nxt = S_FETCH;
        endcase
    end

    assign retire = (cur != S_FETCH) && (nxt == S_FETCH) && !illegal_d;
    assign state  = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: opcode table, corner-case
// sequences and randomized instruction streams against a reference model.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       mem_ready;
    logic       pc_write, pc_write_beq, pc_write_bne, iord, mem_read;
    logic       mem_write, ir_write, reg_dst, mem_to_reg, reg_write, link;
    logic       alu_src_a, zero_imm, illegal_op;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic [3:0] instr_count;

    multicycle_control #(.ALUOP_WIDTH(3), .COUNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_beq(pc_write_beq),
        .pc_write_bne(pc_write_bne), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .link(link),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_source(pc_source), .zero_imm(zero_imm), .alu_op(alu_op),
        .state(state), .illegal_op(illegal_op), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write, pc_write_beq, pc_write_bne, iord, mem_read;
        logic       mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
        logic       link, alu_src_a;
        logic [1:0] alu_src_b, pc_source;
        logic       zero_imm;
        logic [2:0] alu_op;
    } out_t;

    typedef struct packed {
        logic [3:0] st;
        logic       mr;
    } cyc_t;

    typedef struct {
        logic [5:0]  op;
        int          len;
        logic [23:0] seq;
        logic        ill;
    } vec_t;

    out_t act;
    assign act = {pc_write, pc_write_beq, pc_write_bne, iord, mem_read,
                  mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                  link, alu_src_a, alu_src_b, pc_source, zero_imm, alu_op};

    out_t base [13];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    logic exp_ill = 1'b0;

    task automatic chk(input string name, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, a, e);
        end
    endtask

    // Per-state output table from the control description
    task automatic init_table();
        out_t t;
        for (int i = 0; i < 13; i++) base[i] = '0;
        t = '0; t.mem_read = 1; t.alu_src_b = 1; t.alu_op = 3; base[0] = t;
        t = '0; t.alu_src_b = 3; t.alu_op = 3; base[1] = t;
        t = '0; t.alu_src_a = 1; t.alu_src_b = 2; t.alu_op = 3; base[2] = t;
        t = '0; t.mem_read = 1; t.iord = 1; base[3] = t;
        t = '0; t.reg_write = 1; t.mem_to_reg = 1; base[4] = t;
        t = '0; t.mem_write = 1; t.iord = 1; base[5] = t;
        t = '0; t.alu_src_a = 1; t.alu_op = 7; base[6] = t;
        t = '0; t.reg_write = 1; t.reg_dst = 1; base[7] = t;
        t = '0; t.alu_src_a = 1; t.alu_op = 4; t.pc_source = 1; base[8] = t;
        t = '0; t.pc_write = 1; t.pc_source = 2; base[9] = t;
        t = '0; t.alu_src_a = 1; t.alu_src_b = 2; base[10] = t;
        t = '0; t.reg_write = 1; base[11] = t;
        t = '0; t.pc_write = 1; t.pc_source = 2; t.reg_write = 1;
        t.link = 1; base[12] = t;
    endtask

    function automatic out_t exp_out(input logic [3:0] s,
                                     input logic [5:0] opq, input logic mr);
        out_t o;
        o = base[s];
        if (s == 0 && mr) begin
            o.ir_write = 1;
            o.pc_write = 1;
        end
        if (s == 10 || s == 11) begin
            o.alu_op   = (opq == 6'h0d) ? 3'd1 : (opq == 6'h0c) ? 3'd0 :
                         (opq == 6'h0f) ? 3'd5 : 3'd3;
            o.zero_imm = (opq == 6'h0d) || (opq == 6'h0c);
        end
        if (s == 8) begin
            o.pc_write_beq = (opq == 6'h04);
            o.pc_write_bne = (opq == 6'h05);
        end
        return o;
    endfunction

    // One cycle: drive at the falling edge, compare 1 time unit later
    task automatic cycle(input logic [3:0] st, input logic mr,
                         input logic [5:0] opc, input bit first);
        @(negedge clk);
        mem_ready = mr;
        op = (st == 4'd1) ? opc : 6'($urandom);
        #1;
        chk($sformatf("state op=%0h", opc), 32'(state), 32'(st));
        chk($sformatf("outs op=%0h st=%0d", opc, st), 32'(act),
            32'(exp_out(st, opc, mr)));
        chk($sformatf("count op=%0h", opc), 32'(instr_count), 32'(exp_cnt));
        chk($sformatf("illegal op=%0h", opc), 32'(illegal_op),
            32'(first && exp_ill));
    endtask

    task automatic run_instr(input logic [5:0] opc, input int fw,
                             input int mw);
        cyc_t q[$];
        logic ill = 1'b0;
        for (int i = 0; i < fw; i++) q.push_back({4'd0, 1'b0});
        q.push_back({4'd0, 1'b1});
        q.push_back({4'd1, 1'($urandom)});
        case (opc)
            6'h23: begin
                q.push_back({4'd2, 1'($urandom)});
                for (int i = 0; i < mw; i++) q.push_back({4'd3, 1'b0});
                q.push_back({4'd3, 1'b1});
                q.push_back({4'd4, 1'($urandom)});
            end
            6'h2b: begin
                q.push_back({4'd2, 1'($urandom)});
                for (int i = 0; i < mw; i++) q.push_back({4'd5, 1'b0});
                q.push_back({4'd5, 1'b1});
            end
            6'h00: begin
                q.push_back({4'd6, 1'($urandom)});
                q.push_back({4'd7, 1'($urandom)});
            end
            6'h08, 6'h0d, 6'h0c, 6'h0f: begin
                q.push_back({4'd10, 1'($urandom)});
                q.push_back({4'd11, 1'($urandom)});
            end
            6'h04, 6'h05: q.push_back({4'd8, 1'($urandom)});
            6'h02:        q.push_back({4'd9, 1'($urandom)});
            6'h03:        q.push_back({4'd12, 1'($urandom)});
            default:      ill = 1'b1;
        endcase
        foreach (q[i]) cycle(q[i].st, q[i].mr, opc, i == 0);
        if (!ill) exp_cnt = (exp_cnt + 1) % 16;
        exp_ill = ill;
    endtask

    vec_t vecs [12];
    logic [5:0] legal [12] = '{6'h00, 6'h08, 6'h0d, 6'h0c, 6'h0f, 6'h23,
                               6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h00};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        init_table();
        vecs[0]  = '{6'h23, 5, 24'h43210, 1'b0};
        vecs[1]  = '{6'h2b, 4, 24'h05210, 1'b0};
        vecs[2]  = '{6'h00, 4, 24'h07610, 1'b0};
        vecs[3]  = '{6'h08, 4, 24'h0ba10, 1'b0};
        vecs[4]  = '{6'h0d, 4, 24'h0ba10, 1'b0};
        vecs[5]  = '{6'h0c, 4, 24'h0ba10, 1'b0};
        vecs[6]  = '{6'h0f, 4, 24'h0ba10, 1'b0};
        vecs[7]  = '{6'h04, 3, 24'h00810, 1'b0};
        vecs[8]  = '{6'h05, 3, 24'h00810, 1'b0};
        vecs[9]  = '{6'h02, 3, 24'h00910, 1'b0};
        vecs[10] = '{6'h03, 3, 24'h00c10, 1'b0};
        vecs[11] = '{6'h3f, 2, 24'h00010, 1'b1};

        reset = 1'b0;
        mem_ready = 1'b0;
        op = 6'd0;
        #1 reset = 1'b1;
        mem_ready = 1'b1;
        #2;
        chk("reset state", 32'(state), 32'd0);
        chk("reset outs", 32'(act), 32'(exp_out(4'd0, 6'd0, 1'b0)));
        chk("reset count", 32'(instr_count), 32'd0);
        chk("reset illegal", 32'(illegal_op), 32'd0);
        mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Opcode table with mem_ready held high
        for (int v = 0; v < 12; v++) begin
            for (int c = 0; c < vecs[v].len; c++) begin
                logic [23:0] s;
                s = vecs[v].seq;
                cycle(s[4*c +: 4], 1'b1, vecs[v].op, c == 0);
            end
            if (!vecs[v].ill) exp_cnt = (exp_cnt + 1) % 16;
            exp_ill = vecs[v].ill;
        end

        // FETCH wait states, then illegal op followed by a jump
        run_instr(6'h02, 3, 0);
        run_instr(6'h3f, 0, 0);
        run_instr(6'h02, 0, 0);
        run_instr(6'h23, 2, 3);

        // Reset asserted while a store waits in MEM_WR
        cycle(4'd0, 1'b1, 6'h2b, 1'b0);
        cycle(4'd1, 1'b0, 6'h2b, 1'b0);
        cycle(4'd2, 1'b0, 6'h2b, 1'b0);
        cycle(4'd5, 1'b0, 6'h2b, 1'b0);
        #1 reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("midreset state", 32'(state), 32'd0);
        chk("midreset mem_write", 32'(mem_write), 32'd0);
        chk("midreset ir_write", 32'(ir_write), 32'd0);
        chk("midreset count", 32'(instr_count), 32'd0);
        mem_ready = 1'b0;
        exp_cnt = 0;
        exp_ill = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post reset outs", 32'(act), 32'(exp_out(4'd0, 6'd0, 1'b0)));

        // 16 jumps wrap the 4-bit counter back to zero
        for (int i = 0; i < 16; i++) run_instr(6'h02, 0, 0);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("wrap count", 32'(instr_count), 32'd0);

        for (int n = 0; n < 300; n++) begin
            int k;
            logic [5:0] o;
            k = $urandom_range(0, 12);
            o = (k == 12) ? 6'($urandom) : legal[k];
            run_instr(o, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
